// File: rtl/timed_decoder_if.sv
// Handshake and output bundle for timed_decoder: index/mode/clear in, held select out.
interface timed_decoder_if #(
    parameter int NUM_WIRE = 4
) ();
    localparam int AW = $clog2(NUM_WIRE);

    logic [AW-1:0]       a_i;
    logic                a_valid_i;
    logic                a_ready_o;
    logic                mode_i;
    logic                clear_i;
    logic [NUM_WIRE-1:0] d_o;
    logic                busy_o;
    logic                err_o;

    modport master (
        output a_i, a_valid_i, mode_i, clear_i,
        input  a_ready_o, d_o, busy_o, err_o
    );

    modport slave (
        input  a_i, a_valid_i, mode_i, clear_i,
        output a_ready_o, d_o, busy_o, err_o
    );
endinterface

// File: rtl/timed_decoder.sv
// Registered one-hot/accumulating decoder holding each accepted index for HOLD_CYCLES cycles.
// d_o updates one cycle after transfer; a_ready_o is low while holding, during clear and reset.
module timed_decoder #(
    parameter int NUM_WIRE    = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    timed_decoder_if.slave   bus
);
    localparam int AW = $clog2(NUM_WIRE);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [AW:0]     NW_L     = (AW + 1)'(NUM_WIRE);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_WIRE-1:0] d_q, d_d;
    logic                mode_q, mode_d;
    logic                err_q, err_d;

    logic                transfer;
    logic                in_range;
    logic [NUM_WIRE-1:0] onehot;

    assign bus.a_ready_o = (state_q == IDLE) & ~bus.clear_i & ~rst_i;
    assign transfer      = bus.a_valid_i & bus.a_ready_o;
    assign in_range      = ({1'b0, bus.a_i} < NW_L);
    assign onehot        = {{(NUM_WIRE-1){1'b0}}, 1'b1} << bus.a_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        mode_d  = mode_q;
        err_d   = 1'b0;

        // clear wins over both a pending transfer and an ongoing hold
        if (bus.clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            d_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        if (in_range) begin
                            mode_d  = bus.mode_i;
                            d_d     = bus.mode_i ? (d_q | onehot) : onehot;
                            cnt_d   = CNT_LOAD;
                            state_d = HOLD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d = IDLE;
                        if (!mode_q) begin
                            d_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    assign bus.d_o    = d_q;
    assign bus.busy_o = (state_q == HOLD);
    assign bus.err_o  = err_q;
endmodule

// File: tb/tb_timed_decoder.sv
// Three decoder configurations driven by a directed table and by a random stream against a cycle model.
module tb_timed_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NW [3] = '{4, 5, 4};
    localparam int HC [3] = '{1, 3, 4};
    localparam int AWD[3] = '{2, 3, 2};

    logic       rst_v [3];
    logic       clr_v [3];
    logic       vld_v [3];
    logic       mode_v[3];
    logic [2:0] a_v   [3];

    logic [4:0] o_d   [3];
    logic       o_rdy [3];
    logic       o_busy[3];
    logic       o_err [3];

    timed_decoder_if #(.NUM_WIRE(4)) tdi0 ();
    timed_decoder_if #(.NUM_WIRE(5)) tdi1 ();
    timed_decoder_if #(.NUM_WIRE(4)) tdi2 ();

    timed_decoder #(.NUM_WIRE(4), .HOLD_CYCLES(1)) dut0 (.clk_i(clk), .rst_i(rst_v[0]), .bus(tdi0));
    timed_decoder #(.NUM_WIRE(5), .HOLD_CYCLES(3)) dut1 (.clk_i(clk), .rst_i(rst_v[1]), .bus(tdi1));
    timed_decoder #(.NUM_WIRE(4), .HOLD_CYCLES(4)) dut2 (.clk_i(clk), .rst_i(rst_v[2]), .bus(tdi2));

    assign tdi0.a_i = a_v[0][1:0];
    assign tdi0.a_valid_i = vld_v[0];
    assign tdi0.mode_i = mode_v[0];
    assign tdi0.clear_i = clr_v[0];
    assign tdi1.a_i = a_v[1];
    assign tdi1.a_valid_i = vld_v[1];
    assign tdi1.mode_i = mode_v[1];
    assign tdi1.clear_i = clr_v[1];
    assign tdi2.a_i = a_v[2][1:0];
    assign tdi2.a_valid_i = vld_v[2];
    assign tdi2.mode_i = mode_v[2];
    assign tdi2.clear_i = clr_v[2];

    assign o_d[0] = {1'b0, tdi0.d_o};
    assign o_d[1] = tdi1.d_o;
    assign o_d[2] = {1'b0, tdi2.d_o};
    assign o_rdy[0] = tdi0.a_ready_o;
    assign o_rdy[1] = tdi1.a_ready_o;
    assign o_rdy[2] = tdi2.a_ready_o;
    assign o_busy[0] = tdi0.busy_o;
    assign o_busy[1] = tdi1.busy_o;
    assign o_busy[2] = tdi2.busy_o;
    assign o_err[0] = tdi0.err_o;
    assign o_err[1] = tdi1.err_o;
    assign o_err[2] = tdi2.err_o;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int dut;
        bit rst, clr, vld;
        int a;
        bit mode;
        bit rdy;
        int d;
        bit busy, err;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(int dut, bit rst, bit clr, bit vld, int a, bit mode,
                                bit rdy, int d, bit busy, bit err);
        vec_t v;
        v.dut = dut; v.rst = rst; v.clr = clr; v.vld = vld; v.a = a; v.mode = mode;
        v.rdy = rdy; v.d = d; v.busy = busy; v.err = err;
        tbl.push_back(v);
    endfunction

    // Model: remaining hold cycles, select bits, whether the current hold clears on expiry.
    int m_left[3];
    int m_d[3];
    bit m_pulse[3];
    bit m_err[3];

    task automatic model_edge(input int i);
        int a_eff;
        a_eff = int'(a_v[i]) % (1 << AWD[i]);
        if (rst_v[i]) begin
            m_left[i] = 0; m_d[i] = 0; m_err[i] = 0; m_pulse[i] = 1;
        end else if (clr_v[i]) begin
            m_left[i] = 0; m_d[i] = 0; m_err[i] = 0;
        end else if (m_left[i] > 0) begin
            m_left[i]--;
            if (m_left[i] == 0 && m_pulse[i]) m_d[i] = 0;
            m_err[i] = 0;
        end else begin
            m_err[i] = 0;
            if (vld_v[i]) begin
                if (a_eff < NW[i]) begin
                    m_pulse[i] = !mode_v[i];
                    m_d[i] = mode_v[i] ? (m_d[i] | (1 << a_eff)) : (1 << a_eff);
                    m_left[i] = HC[i];
                end else begin
                    m_err[i] = 1;
                end
            end
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 0; clr_v[i] = 0; vld_v[i] = 0; mode_v[i] = 0; a_v[i] = '0;
        end
    endtask

    initial begin
        idle_all();
        for (int i = 0; i < 3; i++) rst_v[i] = 1;
        repeat (2) @(posedge clk);
        #1;
        idle_all();

        // HOLD_CYCLES=1 pulse
        add(0, 1,0,0,0,0, 0, 0,0,0);
        add(0, 0,0,1,2,0, 1, 'b0100,1,0);
        add(0, 0,0,1,3,0, 0, 0,0,0);
        add(0, 0,0,0,0,0, 1, 0,0,0);
        // HOLD_CYCLES=3 pulse with valid held, then out-of-range indices on NUM_WIRE=5
        add(1, 1,0,0,0,0, 0, 0,0,0);
        add(1, 0,0,1,1,0, 1, 'b00010,1,0);
        add(1, 0,0,1,1,0, 0, 'b00010,1,0);
        add(1, 0,0,1,1,0, 0, 'b00010,1,0);
        add(1, 0,0,1,1,0, 0, 0,0,0);
        add(1, 0,0,1,1,0, 1, 'b00010,1,0);
        add(1, 0,0,0,0,0, 0, 'b00010,1,0);
        add(1, 0,0,0,0,0, 0, 'b00010,1,0);
        add(1, 0,0,0,0,0, 0, 0,0,0);
        add(1, 0,0,1,6,0, 1, 0,0,1);
        add(1, 0,0,1,4,1, 1, 'b10000,1,0);
        add(1, 0,0,0,0,0, 0, 'b10000,1,0);
        add(1, 0,0,0,0,0, 0, 'b10000,1,0);
        add(1, 0,0,0,0,0, 0, 'b10000,0,0);
        add(1, 0,0,1,7,0, 1, 'b10000,0,1);
        add(1, 0,0,0,0,0, 1, 'b10000,0,0);
        // accumulate 0,3,1, re-accept 1, then clear together with valid
        add(0, 0,0,1,0,1, 1, 'b0001,1,0);
        add(0, 0,0,0,0,0, 0, 'b0001,0,0);
        add(0, 0,0,1,3,1, 1, 'b1001,1,0);
        add(0, 0,0,0,0,0, 0, 'b1001,0,0);
        add(0, 0,0,1,1,1, 1, 'b1011,1,0);
        add(0, 0,0,0,0,0, 0, 'b1011,0,0);
        add(0, 0,0,1,1,1, 1, 'b1011,1,0);
        add(0, 0,0,0,0,0, 0, 'b1011,0,0);
        add(0, 0,1,1,2,1, 0, 0,0,0);
        add(0, 0,0,0,0,0, 1, 0,0,0);
        // HOLD_CYCLES=4: clear mid-hold, mode_i ignored during hold, reset mid-hold
        add(2, 1,0,0,0,0, 0, 0,0,0);
        add(2, 0,0,1,3,0, 1, 'b1000,1,0);
        add(2, 0,0,0,0,0, 0, 'b1000,1,0);
        add(2, 0,1,1,1,0, 0, 0,0,0);
        add(2, 0,0,1,1,1, 1, 'b0010,1,0);
        add(2, 0,0,0,0,0, 0, 'b0010,1,0);
        add(2, 0,0,0,0,0, 0, 'b0010,1,0);
        add(2, 0,0,0,0,0, 0, 'b0010,1,0);
        add(2, 0,0,0,0,0, 0, 'b0010,0,0);
        add(2, 0,0,1,0,1, 1, 'b0011,1,0);
        add(2, 0,0,0,0,0, 0, 'b0011,1,0);
        add(2, 1,0,0,0,0, 0, 0,0,0);
        add(2, 0,0,0,0,0, 1, 0,0,0);

        for (int r = 0; r < tbl.size(); r++) begin
            int k;
            k = tbl[r].dut;
            idle_all();
            rst_v[k] = tbl[r].rst; clr_v[k] = tbl[r].clr; vld_v[k] = tbl[r].vld;
            a_v[k] = 3'(tbl[r].a); mode_v[k] = tbl[r].mode;
            #1;
            chk($sformatf("vec%0d dut%0d ready", r, k), int'(o_rdy[k]), int'(tbl[r].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d dut%0d d", r, k), int'(o_d[k]), tbl[r].d);
            chk($sformatf("vec%0d dut%0d busy", r, k), int'(o_busy[k]), int'(tbl[r].busy));
            chk($sformatf("vec%0d dut%0d err", r, k), int'(o_err[k]), int'(tbl[r].err));
        end

        for (int i = 0; i < 3; i++) begin
            m_left[i] = 0; m_d[i] = 0; m_pulse[i] = 1; m_err[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                rst_v[i]  = (c < 2) || ($urandom_range(0, 63) == 0);
                clr_v[i]  = ($urandom_range(0, 15) == 0);
                vld_v[i]  = ($urandom_range(0, 3) != 0);
                a_v[i]    = 3'($urandom_range(0, 7));
                mode_v[i] = 1'($urandom_range(0, 1));
            end
            #1;
            for (int i = 0; i < 3; i++)
                chk($sformatf("rnd%0d dut%0d ready", c, i), int'(o_rdy[i]),
                    int'(m_left[i] == 0 && !clr_v[i] && !rst_v[i]));
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_edge(i);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rnd%0d dut%0d d", c, i), int'(o_d[i]), m_d[i]);
                chk($sformatf("rnd%0d dut%0d busy", c, i), int'(o_busy[i]), int'(m_left[i] > 0));
                chk($sformatf("rnd%0d dut%0d err", c, i), int'(o_err[i]), int'(m_err[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
